// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle MIPS32 control unit: state encoding,
// ALU/branch/size codes, opcode/function constants and the decoded control bundle.
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } cuState_t;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_ALU    = 3'd1,
    CLS_BRANCH = 3'd2,
    CLS_JUMP   = 3'd3,
    CLS_LOAD   = 3'd4,
    CLS_STORE  = 3'd5
  } instrClass_t;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_LUI  = 3'd5;
  localparam logic [2:0] ALU_XOR  = 3'd6;
  localparam logic [2:0] ALU_SLTU = 3'd7;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BGEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_BLEZ = 3'd5;
  localparam logic [2:0] BR_BLTZ = 3'd6;

  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_BYTE = 2'd2;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef struct packed {
    instrClass_t cls;
    logic [2:0]  branchCode;
    logic [2:0]  aluFunc;
    logic        aluSrc;
    logic        bitXtend;
    logic [1:0]  rfWriteDataSel;
    logic        rfWriteAddrSel;
    logic [1:0]  memDataSize;
    logic        memBitExt;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_instr_decoder.sv
// Combinational instruction decoder: opc/func/rt to control bundle, class and valid.
// Unsupported encodings produce an all-zero bundle with valid=0.
module instr_decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic [4:0] rt,
  output ctrl_t      ctrl,
  output logic       valid
);

  always_comb begin
    ctrl  = '0;
    valid = 1'b1;
    case (opc)
      OP_RTYPE: begin
        ctrl.cls            = CLS_ALU;
        ctrl.rfWriteAddrSel = 1'b1;
        case (func)
          FN_ADD, FN_ADDU: ctrl.aluFunc = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.aluFunc = ALU_SUB;
          FN_AND:          ctrl.aluFunc = ALU_AND;
          FN_OR:           ctrl.aluFunc = ALU_OR;
          FN_XOR:          ctrl.aluFunc = ALU_XOR;
          FN_SLT:          ctrl.aluFunc = ALU_SLT;
          FN_SLTU:         ctrl.aluFunc = ALU_SLTU;
          default: begin
            ctrl  = '0;
            valid = 1'b0;
          end
        endcase
      end
      // Branch compares run through the ALU as a subtraction of rs and rt/zero.
      OP_REGIMM: begin
        ctrl.cls     = CLS_BRANCH;
        ctrl.aluFunc = ALU_SUB;
        case (rt)
          RT_BGEZ: ctrl.branchCode = BR_BGEZ;
          RT_BLTZ: ctrl.branchCode = BR_BLTZ;
          default: begin
            ctrl  = '0;
            valid = 1'b0;
          end
        endcase
      end
      OP_BEQ:  begin ctrl.cls = CLS_BRANCH; ctrl.aluFunc = ALU_SUB; ctrl.branchCode = BR_BEQ;  end
      OP_BNE:  begin ctrl.cls = CLS_BRANCH; ctrl.aluFunc = ALU_SUB; ctrl.branchCode = BR_BNE;  end
      OP_BLEZ: begin ctrl.cls = CLS_BRANCH; ctrl.aluFunc = ALU_SUB; ctrl.branchCode = BR_BLEZ; end
      OP_BGTZ: begin ctrl.cls = CLS_BRANCH; ctrl.aluFunc = ALU_SUB; ctrl.branchCode = BR_BGTZ; end
      OP_J:    ctrl.cls = CLS_JUMP;
      OP_ADDI, OP_ADDIU: begin ctrl.cls = CLS_ALU; ctrl.aluSrc = 1'b1; ctrl.aluFunc = ALU_ADD;  end
      OP_SLTI:  begin ctrl.cls = CLS_ALU; ctrl.aluSrc = 1'b1; ctrl.aluFunc = ALU_SLT;  end
      OP_SLTIU: begin ctrl.cls = CLS_ALU; ctrl.aluSrc = 1'b1; ctrl.aluFunc = ALU_SLTU; end
      OP_LUI:   begin ctrl.cls = CLS_ALU; ctrl.aluSrc = 1'b1; ctrl.aluFunc = ALU_LUI;  end
      // Logical immediates are zero-extended, everything else sign-extends.
      OP_ANDI: begin ctrl.cls = CLS_ALU; ctrl.aluSrc = 1'b1; ctrl.aluFunc = ALU_AND; ctrl.bitXtend = 1'b1; end
      OP_ORI:  begin ctrl.cls = CLS_ALU; ctrl.aluSrc = 1'b1; ctrl.aluFunc = ALU_OR;  ctrl.bitXtend = 1'b1; end
      OP_XORI: begin ctrl.cls = CLS_ALU; ctrl.aluSrc = 1'b1; ctrl.aluFunc = ALU_XOR; ctrl.bitXtend = 1'b1; end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        ctrl.cls            = CLS_LOAD;
        ctrl.aluSrc         = 1'b1;
        ctrl.rfWriteDataSel = 2'd1;
        ctrl.memDataSize    = (opc == OP_LB || opc == OP_LBU) ? SIZE_BYTE :
                              (opc == OP_LH || opc == OP_LHU) ? SIZE_HALF : SIZE_WORD;
        ctrl.memBitExt      = (opc == OP_LBU || opc == OP_LHU);
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.cls         = CLS_STORE;
        ctrl.aluSrc      = 1'b1;
        ctrl.memDataSize = (opc == OP_SB) ? SIZE_BYTE :
                           (opc == OP_SH) ? SIZE_HALF : SIZE_WORD;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS32 control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memReady stall.
// Optional `define TRAP_EN adds a memory-wait timeout and a sticky TRAP state for faults.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int ALU_FUNC_W  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opc,
  input  logic [5:0]            func,
  input  logic [4:0]            rt,
  input  logic                  memReady,
  output logic                  memReq,
  output logic                  memWrite,
  output logic [1:0]            memDataSize,
  output logic                  memBitExt,
  output logic                  irWrite,
  output logic                  pcWrite,
  output logic                  jmp,
  output logic [2:0]            branch,
  output logic                  rfWriteEnable,
  output logic [1:0]            rfWriteDataSel,
  output logic                  rfWriteAddrSel,
  output logic                  aluSrc,
  output logic [ALU_FUNC_W-1:0] aluFunc,
  output logic                  bitXtend,
  output logic                  invOpcode,
  output logic                  fault,
  output logic [2:0]            state
);

  if (MEM_TIMEOUT < 1) begin : gBadTimeout
    $error("MEM_TIMEOUT must be at least 1");
  end

  cuState_t curState, nextState;
  ctrl_t    decCtrl, ctrlReg;
  logic     decValid;
  logic     armed;
  logic     memPhase;
  logic     timeout;

  instr_decoder uDecoder (
    .opc   (opc),
    .func  (func),
    .rt    (rt),
    .ctrl  (decCtrl),
    .valid (decValid)
  );

  // armed is low for the first cycle after reset so every output reads 0 there.
  assign memPhase = armed && (curState == FETCH || curState == MEM);

`ifdef TRAP_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] waitCnt;
  logic             trapInv;

  assign timeout = memPhase && !memReady && (waitCnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !memPhase || memReady || timeout) waitCnt <= '0;
    else                                         waitCnt <= waitCnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                                 trapInv <= 1'b0;
    else if (curState == DECODE && !decValid) trapInv <= 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      curState <= FETCH;
      armed    <= 1'b0;
      ctrlReg  <= '0;
    end else begin
      armed    <= 1'b1;
      curState <= nextState;
      if (curState == DECODE) ctrlReg <= decCtrl;
    end
  end

  always_comb begin
    nextState = curState;
    case (curState)
      FETCH: begin
        if (armed && memReady) nextState = DECODE;
        else if (timeout)      nextState = TRAP;
      end
      DECODE: begin
        if (decValid) nextState = EXEC;
        else begin
`ifdef TRAP_EN
          nextState = TRAP;
`else
          nextState = FETCH;
`endif
        end
      end
      EXEC: begin
        case (ctrlReg.cls)
          CLS_ALU:             nextState = WB;
          CLS_LOAD, CLS_STORE: nextState = MEM;
          default:             nextState = FETCH;
        endcase
      end
      MEM: begin
        if (memReady)     nextState = (ctrlReg.cls == CLS_LOAD) ? WB : FETCH;
        else if (timeout) nextState = TRAP;
      end
      WB:      nextState = FETCH;
      TRAP:    nextState = TRAP;
      default: nextState = FETCH;
    endcase
  end

  // Strobes follow the state; static controls come straight from the DECODE-exit register.
  always_comb begin
    memReq         = 1'b0;
    memWrite       = 1'b0;
    irWrite        = 1'b0;
    pcWrite        = 1'b0;
    jmp            = 1'b0;
    branch         = BR_NONE;
    rfWriteEnable  = 1'b0;
    invOpcode      = 1'b0;
    fault          = 1'b0;
    aluFunc        = ALU_FUNC_W'(ctrlReg.aluFunc);
    aluSrc         = ctrlReg.aluSrc;
    bitXtend       = ctrlReg.bitXtend;
    rfWriteDataSel = ctrlReg.rfWriteDataSel;
    rfWriteAddrSel = ctrlReg.rfWriteAddrSel;
    memBitExt      = ctrlReg.memBitExt;
    memDataSize    = (curState == FETCH) ? SIZE_WORD : ctrlReg.memDataSize;
    if (armed) begin
      case (curState)
        FETCH: begin
          memReq  = 1'b1;
          irWrite = memReady;
          pcWrite = memReady;
        end
        DECODE: invOpcode = !decValid;
        EXEC: begin
          jmp    = (ctrlReg.cls == CLS_JUMP);
          branch = ctrlReg.branchCode;
        end
        MEM: begin
          memReq   = 1'b1;
          memWrite = (ctrlReg.cls == CLS_STORE);
        end
        WB: rfWriteEnable = 1'b1;
        TRAP: begin
`ifdef TRAP_EN
          invOpcode = trapInv;
          fault     = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign state = curState;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed and randomized instruction streams checked
// cycle by cycle against a phase-level reference model built from an instruction table.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opc, func;
  logic [4:0] rt;
  logic       memReady;
  logic       memReq, memWrite, memBitExt, irWrite, pcWrite, jmp, rfWriteEnable;
  logic       rfWriteAddrSel, aluSrc, bitXtend, invOpcode, fault;
  logic [1:0] memDataSize, rfWriteDataSel;
  logic [2:0] branch, state;
  logic [3:0] aluFunc;

  multicycle_control_unit #(.ALU_FUNC_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .opc(opc), .func(func), .rt(rt), .memReady(memReady),
    .memReq(memReq), .memWrite(memWrite), .memDataSize(memDataSize), .memBitExt(memBitExt),
    .irWrite(irWrite), .pcWrite(pcWrite), .jmp(jmp), .branch(branch),
    .rfWriteEnable(rfWriteEnable), .rfWriteDataSel(rfWriteDataSel),
    .rfWriteAddrSel(rfWriteAddrSel), .aluSrc(aluSrc), .aluFunc(aluFunc),
    .bitXtend(bitXtend), .invOpcode(invOpcode), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  localparam int C_NONE = 0, C_ALU = 1, C_BR = 2, C_J = 3, C_LD = 4, C_ST = 5;

  typedef enum int {P_FW, P_FD, P_DEC, P_EXEC, P_MW, P_MD, P_WB, P_TRAP} phase_t;

  typedef struct {
    logic [5:0] opc;
    logic [5:0] func;
    bit         useFunc;
    logic [4:0] rt;
    bit         useRt;
    int         cls;
    logic [3:0] alu;
    bit         src;
    bit         xt;
    logic [1:0] wsel;
    bit         asel;
    logic [1:0] size;
    bit         ext;
    logic [2:0] br;
  } ref_t;

  ref_t        tbl[$];
  ref_t        cur;
  bit          curValid;
  logic [11:0] expStatic;
  bit          expTrapInv;
  int          nCmp = 0;
  int          nErr = 0;

  function automatic void tAdd(input int o, input int f, input int uf, input int r, input int ur,
                               input int c, input int a, input int s, input int x, input int ws,
                               input int as, input int sz, input int ex, input int b);
    ref_t e;
    e.opc = 6'(o); e.func = 6'(f); e.useFunc = (uf != 0); e.rt = 5'(r); e.useRt = (ur != 0);
    e.cls = c; e.alu = 4'(a); e.src = (s != 0); e.xt = (x != 0); e.wsel = 2'(ws);
    e.asel = (as != 0); e.size = 2'(sz); e.ext = (ex != 0); e.br = 3'(b);
    tbl.push_back(e);
  endfunction

  function automatic bit lookup(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                                output ref_t e);
    e = tbl[0];
    foreach (tbl[i])
      if (tbl[i].opc == o && (!tbl[i].useFunc || tbl[i].func == f) &&
          (!tbl[i].useRt || tbl[i].rt == r)) begin
        e = tbl[i];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic logic [11:0] packStatic(input ref_t r);
    return {r.alu, r.src, r.xt, r.wsel, r.asel, r.size, r.ext};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkZero(input string tag);
    check({tag, ".state"}, 32'(state), 32'd0);
    check({tag, ".outputs"}, 32'({memReq, memWrite, memDataSize, memBitExt, irWrite, pcWrite,
          jmp, branch, rfWriteEnable, rfWriteDataSel, rfWriteAddrSel, aluSrc, aluFunc,
          bitXtend, invOpcode, fault}), 32'd0);
  endtask

  task automatic cycle(input phase_t ph, input bit ready);
    logic [2:0]  eState, eBr;
    logic        eReq, eWr, eIr, ePc, eJ, eWe, eInv, eFault;
    logic [11:0] eSt;
    string       tag;
    eState = 3'd0; eBr = 3'd0; eReq = 0; eWr = 0; eIr = 0; ePc = 0; eJ = 0;
    eWe = 0; eInv = 0; eFault = 0; eSt = expStatic;
    case (ph)
      P_FW:       eReq = 1;
      P_FD:       begin eReq = 1; eIr = 1; ePc = 1; end
      P_DEC:      begin eState = 3'd1; eInv = !curValid; end
      P_EXEC:     begin eState = 3'd2; eJ = (cur.cls == C_J); eBr = cur.br; end
      P_MW, P_MD: begin eState = 3'd3; eReq = 1; eWr = (cur.cls == C_ST); end
      P_WB:       begin eState = 3'd4; eWe = 1; end
      P_TRAP:     begin eState = 3'd5; eFault = 1; eInv = expTrapInv; end
      default: ;
    endcase
    if (ph == P_FW || ph == P_FD) eSt[2:1] = 2'd0;
    memReady = ready;
    @(negedge clk);
    tag = $sformatf("%s opc=%02h", ph.name(), opc);
    check({tag, " state"}, 32'(state), 32'(eState));
    check({tag, " strobes"}, 32'({memReq, memWrite, irWrite, pcWrite, jmp, branch,
          rfWriteEnable, invOpcode, fault}),
          32'({eReq, eWr, eIr, ePc, eJ, eBr, eWe, eInv, eFault}));
    check({tag, " statics"}, 32'({aluFunc, aluSrc, bitXtend, rfWriteDataSel, rfWriteAddrSel,
          memDataSize, memBitExt}), 32'(eSt));
    @(posedge clk);
    #1;
    if (ph == P_DEC) begin
      expStatic  = curValid ? packStatic(cur) : 12'd0;
      expTrapInv = !curValid;
    end
  endtask

  task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] r,
                          input int fw, input int mw);
    opc = o; func = f; rt = r;
    curValid = lookup(o, f, r, cur);
    repeat (fw) cycle(P_FW, 1'b0);
    cycle(P_FD, 1'b1);
    cycle(P_DEC, 1'($urandom));
    if (!curValid) begin
`ifdef TRAP_EN
      repeat (3) cycle(P_TRAP, 1'($urandom));
`endif
    end else begin
      cycle(P_EXEC, 1'($urandom));
      if (cur.cls == C_LD || cur.cls == C_ST) begin
        repeat (mw) cycle(P_MW, 1'b0);
        cycle(P_MD, 1'b1);
      end
      if (cur.cls == C_ALU || cur.cls == C_LD) cycle(P_WB, 1'($urandom));
    end
  endtask

  task automatic doReset(input int cyc);
    rst = 1'b1;
    memReady = 1'b1;
    repeat (cyc) begin
      @(posedge clk);
      #1;
      checkZero("reset_held");
    end
    rst = 1'b0;
    @(negedge clk);
    checkZero("post_reset");
    @(posedge clk);
    #1;
    expStatic  = 12'd0;
    expTrapInv = 1'b0;
  endtask

  initial begin
    logic [5:0] ro, rf;
    logic [4:0] rr;
    int         pick;
    // R-type ALU
    tAdd(6'h00, 6'h20, 1, 0, 0, C_ALU, 0, 0, 0, 0, 1, 0, 0, 0);
    tAdd(6'h00, 6'h21, 1, 0, 0, C_ALU, 0, 0, 0, 0, 1, 0, 0, 0);
    tAdd(6'h00, 6'h22, 1, 0, 0, C_ALU, 1, 0, 0, 0, 1, 0, 0, 0);
    tAdd(6'h00, 6'h23, 1, 0, 0, C_ALU, 1, 0, 0, 0, 1, 0, 0, 0);
    tAdd(6'h00, 6'h24, 1, 0, 0, C_ALU, 2, 0, 0, 0, 1, 0, 0, 0);
    tAdd(6'h00, 6'h25, 1, 0, 0, C_ALU, 3, 0, 0, 0, 1, 0, 0, 0);
    tAdd(6'h00, 6'h26, 1, 0, 0, C_ALU, 6, 0, 0, 0, 1, 0, 0, 0);
    tAdd(6'h00, 6'h2A, 1, 0, 0, C_ALU, 4, 0, 0, 0, 1, 0, 0, 0);
    tAdd(6'h00, 6'h2B, 1, 0, 0, C_ALU, 7, 0, 0, 0, 1, 0, 0, 0);
    // immediates and LUI
    tAdd(6'h08, 0, 0, 0, 0, C_ALU, 0, 1, 0, 0, 0, 0, 0, 0);
    tAdd(6'h09, 0, 0, 0, 0, C_ALU, 0, 1, 0, 0, 0, 0, 0, 0);
    tAdd(6'h0A, 0, 0, 0, 0, C_ALU, 4, 1, 0, 0, 0, 0, 0, 0);
    tAdd(6'h0B, 0, 0, 0, 0, C_ALU, 7, 1, 0, 0, 0, 0, 0, 0);
    tAdd(6'h0C, 0, 0, 0, 0, C_ALU, 2, 1, 1, 0, 0, 0, 0, 0);
    tAdd(6'h0D, 0, 0, 0, 0, C_ALU, 3, 1, 1, 0, 0, 0, 0, 0);
    tAdd(6'h0E, 0, 0, 0, 0, C_ALU, 6, 1, 1, 0, 0, 0, 0, 0);
    tAdd(6'h0F, 0, 0, 0, 0, C_ALU, 5, 1, 0, 0, 0, 0, 0, 0);
    // branches and jump
    tAdd(6'h04, 0, 0, 0, 0, C_BR, 1, 0, 0, 0, 0, 0, 0, 1);
    tAdd(6'h05, 0, 0, 0, 0, C_BR, 1, 0, 0, 0, 0, 0, 0, 2);
    tAdd(6'h01, 0, 0, 1, 1, C_BR, 1, 0, 0, 0, 0, 0, 0, 3);
    tAdd(6'h07, 0, 0, 0, 0, C_BR, 1, 0, 0, 0, 0, 0, 0, 4);
    tAdd(6'h06, 0, 0, 0, 0, C_BR, 1, 0, 0, 0, 0, 0, 0, 5);
    tAdd(6'h01, 0, 0, 0, 1, C_BR, 1, 0, 0, 0, 0, 0, 0, 6);
    tAdd(6'h02, 0, 0, 0, 0, C_J,  0, 0, 0, 0, 0, 0, 0, 0);
    // loads and stores
    tAdd(6'h23, 0, 0, 0, 0, C_LD, 0, 1, 0, 1, 0, 0, 0, 0);
    tAdd(6'h21, 0, 0, 0, 0, C_LD, 0, 1, 0, 1, 0, 1, 0, 0);
    tAdd(6'h25, 0, 0, 0, 0, C_LD, 0, 1, 0, 1, 0, 1, 1, 0);
    tAdd(6'h20, 0, 0, 0, 0, C_LD, 0, 1, 0, 1, 0, 2, 0, 0);
    tAdd(6'h24, 0, 0, 0, 0, C_LD, 0, 1, 0, 1, 0, 2, 1, 0);
    tAdd(6'h2B, 0, 0, 0, 0, C_ST, 0, 1, 0, 0, 0, 0, 0, 0);
    tAdd(6'h29, 0, 0, 0, 0, C_ST, 0, 1, 0, 0, 0, 1, 0, 0);
    tAdd(6'h28, 0, 0, 0, 0, C_ST, 0, 1, 0, 0, 0, 2, 0, 0);

    rst = 1'b1; memReady = 1'b0; opc = 6'h00; func = 6'h00; rt = 5'h00;
    expStatic = 12'd0; expTrapInv = 1'b0; curValid = 1'b1; cur = tbl[0];
    doReset(2);

    runInstr(6'h08, 6'h15, 5'h03, 0, 0);           // ADDI, zero wait
    runInstr(6'h24, 6'h00, 5'h02, 2, 1);           // LBU, 2+1 wait cycles
    runInstr(6'h29, 6'h11, 5'h04, 0, 0);           // SH
    runInstr(6'h05, 6'h3F, 5'h07, 0, 0);           // BNE
    runInstr(6'h02, 6'h2A, 5'h1F, 0, 0);           // J
    runInstr(6'h01, 6'h00, 5'h01, 0, 0);           // BGEZ
    runInstr(6'h01, 6'h00, 5'h00, 1, 0);           // BLTZ
    runInstr(6'h00, 6'h22, 5'h09, 0, 0);           // SUB
    runInstr(6'h00, 6'h27, 5'h09, 0, 0);           // NOR: unsupported function
`ifdef TRAP_EN
    doReset(1);
`endif

    for (int n = 0; n < 40; n++) begin
      pick = int'($urandom_range(0, tbl.size() - 1));
      ro = tbl[pick].opc;
      rf = tbl[pick].useFunc ? tbl[pick].func : 6'($urandom);
      rr = tbl[pick].useRt ? tbl[pick].rt : 5'($urandom);
`ifndef TRAP_EN
      if ($urandom_range(0, 4) == 0) begin
        ro = 6'($urandom); rf = 6'($urandom); rr = 5'($urandom);
      end
`endif
      runInstr(ro, rf, rr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // reset lands while a store is stalled in MEM
    opc = 6'h2B; func = 6'h05; rt = 5'h02;
    curValid = lookup(opc, func, rt, cur);
    cycle(P_FD, 1'b1);
    cycle(P_DEC, 1'b0);
    cycle(P_EXEC, 1'b1);
    cycle(P_MW, 1'b0);
    doReset(1);
    runInstr(6'h0D, 6'h00, 5'h01, 0, 0);           // ORI after restart

`ifdef TRAP_EN
    opc = 6'h23; func = 6'h00; rt = 5'h03;
    curValid = lookup(opc, func, rt, cur);
    cycle(P_FD, 1'b1);
    cycle(P_DEC, 1'b0);
    cycle(P_EXEC, 1'b0);
    repeat (15) cycle(P_MW, 1'b0);
    repeat (4) cycle(P_TRAP, 1'($urandom));
    doReset(1);
    runInstr(6'h08, 6'h00, 5'h00, 0, 0);
`endif

    runInstr(6'h01, 6'h00, 5'h05, 0, 0);           // REGIMM with unsupported rt
`ifdef TRAP_EN
    doReset(1);
`endif
    runInstr(6'h0F, 6'h00, 5'h00, 0, 0);           // LUI

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
